axi_rr_arbiter: RTL



---
 rtl/axi_rr_arbiter_if.sv | 69 ++++++
 rtl/axi_rr_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/axi_rr_arbiter_if.sv
// AXI channel bundle shared by the arbiter's upstream and downstream ports.
// The master modport is the initiator side; the slave modport is the target side.
interface axi_channel #(
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 64
);
  localparam int unsigned StrbWidth = DATA_WIDTH / 8;

  logic                  ar_valid;
  logic                  ar_ready;
  logic [ID_WIDTH-1:0]   ar_id;
  logic [ADDR_WIDTH-1:0] ar_addr;
  logic [7:0]            ar_len;
  logic [2:0]            ar_size;
  logic [1:0]            ar_burst;

  logic                  aw_valid;
  logic                  aw_ready;
  logic [ID_WIDTH-1:0]   aw_id;
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [7:0]            aw_len;
  logic [2:0]            aw_size;
  logic [1:0]            aw_burst;

  logic                  w_valid;
  logic                  w_ready;
  logic [DATA_WIDTH-1:0] w_data;
  logic [StrbWidth-1:0]  w_strb;
  logic                  w_last;

  logic                  b_valid;
  logic                  b_ready;
  logic [ID_WIDTH-1:0]   b_id;
  logic [1:0]            b_resp;

  logic                  r_valid;
  logic                  r_ready;
  logic [ID_WIDTH-1:0]   r_id;
  logic [DATA_WIDTH-1:0] r_data;
  logic [1:0]            r_resp;
  logic                  r_last;

  modport master (
    output ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst,
    input  ar_ready,
    output aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst,
    input  aw_ready,
    output w_valid, w_data, w_strb, w_last,
    input  w_ready,
    input  b_valid, b_id, b_resp,
    output b_ready,
    input  r_valid, r_id, r_data, r_resp, r_last,
    output r_ready
  );

  modport slave (
    input  ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst,
    output ar_ready,
    input  aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst,
    output aw_ready,
    input  w_valid, w_data, w_strb, w_last,
    output w_ready,
    output b_valid, b_id, b_resp,
    input  b_ready,
    output r_valid, r_id, r_data, r_resp, r_last,
    input  r_ready
  );
endinterface

// File: rtl/axi_rr_arbiter.sv
// Round-robin N:1 AXI arbiter; read and write directions are granted independently
// with one transaction in flight per direction, so IDs pass through untouched.
module axi_rr_arbiter #(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned ID_WIDTH    = 4,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 64
) (
  input logic        clk,
  input logic        rst,
  axi_channel.slave  master [NUM_MASTERS],
  axi_channel.master slave
);
  localparam int unsigned IdxWidth  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int unsigned StrbWidth = DATA_WIDTH / 8;

  typedef logic [IdxWidth-1:0] idx_t;
  typedef enum logic [1:0] {RdIdle, RdAddr, RdData} rd_state_e;
  typedef enum logic [1:0] {WrIdle, WrBusy, WrResp} wr_state_e;

  // First requester at or after ptr, modulo NUM_MASTERS.
  function automatic idx_t rr_pick(input logic [NUM_MASTERS-1:0] req, input idx_t ptr);
    idx_t win;
    int   idx;
    win = ptr;
    for (int k = int'(NUM_MASTERS) - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % int'(NUM_MASTERS);
      if (req[idx_t'(idx)]) win = idx_t'(idx);
    end
    return win;
  endfunction

  function automatic idx_t rr_next(input idx_t win);
    return (32'(win) == NUM_MASTERS - 1) ? '0 : win + idx_t'(1);
  endfunction

  // Upstream signals gathered into arrays so they can be muxed by the registered grant.
  logic [NUM_MASTERS-1:0] m_ar_valid, m_aw_valid, m_w_valid, m_w_last, m_b_ready, m_r_ready;
  logic [ID_WIDTH-1:0]    m_ar_id    [NUM_MASTERS];
  logic [ADDR_WIDTH-1:0]  m_ar_addr  [NUM_MASTERS];
  logic [7:0]             m_ar_len   [NUM_MASTERS];
  logic [2:0]             m_ar_size  [NUM_MASTERS];
  logic [1:0]             m_ar_burst [NUM_MASTERS];
  logic [ID_WIDTH-1:0]    m_aw_id    [NUM_MASTERS];
  logic [ADDR_WIDTH-1:0]  m_aw_addr  [NUM_MASTERS];
  logic [7:0]             m_aw_len   [NUM_MASTERS];
  logic [2:0]             m_aw_size  [NUM_MASTERS];
  logic [1:0]             m_aw_burst [NUM_MASTERS];
  logic [DATA_WIDTH-1:0]  m_w_data   [NUM_MASTERS];
  logic [StrbWidth-1:0]   m_w_strb   [NUM_MASTERS];

  rd_state_e rd_state_q, rd_state_d;
  idx_t      rd_gnt_q, rd_gnt_d, rd_ptr_q, rd_ptr_d;
  wr_state_e wr_state_q, wr_state_d;
  idx_t      wr_gnt_q, wr_gnt_d, wr_ptr_q, wr_ptr_d;
  logic      aw_done_q, aw_done_d, w_done_q, w_done_d;

  logic rd_addr_ph, rd_data_ph, wr_busy_ph, wr_resp_ph;
  assign rd_addr_ph = (rd_state_q == RdAddr);
  assign rd_data_ph = (rd_state_q == RdData);
  assign wr_busy_ph = (wr_state_q == WrBusy);
  assign wr_resp_ph = (wr_state_q == WrResp);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state_q <= RdIdle;
      rd_gnt_q   <= '0;
      rd_ptr_q   <= '0;
      wr_state_q <= WrIdle;
      wr_gnt_q   <= '0;
      wr_ptr_q   <= '0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      rd_gnt_q   <= rd_gnt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_state_q <= wr_state_d;
      wr_gnt_q   <= wr_gnt_d;
      wr_ptr_q   <= wr_ptr_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
    end
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rd_gnt_d   = rd_gnt_q;
    rd_ptr_d   = rd_ptr_q;
    unique case (rd_state_q)
      RdIdle: begin
        if (|m_ar_valid) begin
          rd_gnt_d   = rr_pick(m_ar_valid, rd_ptr_q);
          rd_ptr_d   = rr_next(rd_gnt_d);
          rd_state_d = RdAddr;
        end
      end
      RdAddr: if (slave.ar_valid && slave.ar_ready) rd_state_d = RdData;
      RdData: if (slave.r_valid && slave.r_ready && slave.r_last) rd_state_d = RdIdle;
      default: rd_state_d = RdIdle;
    endcase
  end

  always_comb begin
    wr_state_d = wr_state_q;
    wr_gnt_d   = wr_gnt_q;
    wr_ptr_d   = wr_ptr_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    unique case (wr_state_q)
      WrIdle: begin
        if (|m_aw_valid) begin
          wr_gnt_d   = rr_pick(m_aw_valid, wr_ptr_q);
          wr_ptr_d   = rr_next(wr_gnt_d);
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          wr_state_d = WrBusy;
        end
      end
      WrBusy: begin
        // AW and W complete independently; leave once both have, even in the same cycle.
        aw_done_d = aw_done_q | (slave.aw_valid & slave.aw_ready);
        w_done_d  = w_done_q | (slave.w_valid & slave.w_ready & slave.w_last);
        if (aw_done_d && w_done_d) wr_state_d = WrResp;
      end
      WrResp: if (slave.b_valid && slave.b_ready) wr_state_d = WrIdle;
      default: wr_state_d = WrIdle;
    endcase
  end

  assign slave.ar_valid = rd_addr_ph & m_ar_valid[rd_gnt_q];
  assign slave.ar_id    = m_ar_id[rd_gnt_q];
  assign slave.ar_addr  = m_ar_addr[rd_gnt_q];
  assign slave.ar_len   = m_ar_len[rd_gnt_q];
  assign slave.ar_size  = m_ar_size[rd_gnt_q];
  assign slave.ar_burst = m_ar_burst[rd_gnt_q];
  assign slave.r_ready  = rd_data_ph & m_r_ready[rd_gnt_q];

  assign slave.aw_valid = wr_busy_ph & ~aw_done_q & m_aw_valid[wr_gnt_q];
  assign slave.aw_id    = m_aw_id[wr_gnt_q];
  assign slave.aw_addr  = m_aw_addr[wr_gnt_q];
  assign slave.aw_len   = m_aw_len[wr_gnt_q];
  assign slave.aw_size  = m_aw_size[wr_gnt_q];
  assign slave.aw_burst = m_aw_burst[wr_gnt_q];
  assign slave.w_valid  = wr_busy_ph & ~w_done_q & m_w_valid[wr_gnt_q];
  assign slave.w_data   = m_w_data[wr_gnt_q];
  assign slave.w_strb   = m_w_strb[wr_gnt_q];
  assign slave.w_last   = m_w_last[wr_gnt_q];
  assign slave.b_ready  = wr_resp_ph & m_b_ready[wr_gnt_q];

  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_master
    logic rd_sel, wr_sel;
    assign rd_sel = (rd_gnt_q == idx_t'(i));
    assign wr_sel = (wr_gnt_q == idx_t'(i));

    assign m_ar_valid[i] = master[i].ar_valid;
    assign m_ar_id[i]    = master[i].ar_id;
    assign m_ar_addr[i]  = master[i].ar_addr;
    assign m_ar_len[i]   = master[i].ar_len;
    assign m_ar_size[i]  = master[i].ar_size;
    assign m_ar_burst[i] = master[i].ar_burst;
    assign m_r_ready[i]  = master[i].r_ready;
    assign m_aw_valid[i] = master[i].aw_valid;
    assign m_aw_id[i]    = master[i].aw_id;
    assign m_aw_addr[i]  = master[i].aw_addr;
    assign m_aw_len[i]   = master[i].aw_len;
    assign m_aw_size[i]  = master[i].aw_size;
    assign m_aw_burst[i] = master[i].aw_burst;
    assign m_w_valid[i]  = master[i].w_valid;
    assign m_w_data[i]   = master[i].w_data;
    assign m_w_strb[i]   = master[i].w_strb;
    assign m_w_last[i]   = master[i].w_last;
    assign m_b_ready[i]  = master[i].b_ready;

    // Payloads are broadcast; only the valid/ready strobes are steered by grant.
    assign master[i].ar_ready = rd_addr_ph & rd_sel & slave.ar_ready;
    assign master[i].r_valid  = rd_data_ph & rd_sel & slave.r_valid;
    assign master[i].r_id     = slave.r_id;
    assign master[i].r_data   = slave.r_data;
    assign master[i].r_resp   = slave.r_resp;
    assign master[i].r_last   = slave.r_last;
    assign master[i].aw_ready = wr_busy_ph & wr_sel & ~aw_done_q & slave.aw_ready;
    assign master[i].w_ready  = wr_busy_ph & wr_sel & ~w_done_q & slave.w_ready;
    assign master[i].b_valid  = wr_resp_ph & wr_sel & slave.b_valid;
    assign master[i].b_id     = slave.b_id;
    assign master[i].b_resp   = slave.b_resp;
  end
endmodule
